// File: rtl/shift_norm_pipe_pkg.sv
// Shared definitions for the pipelined left-normalizer: stage count, parameter
// legality check and the per-stage tag that travels beside the data word.
package shift_norm_pipe_pkg;

    typedef struct packed {
        logic zero;
        logic valid;
    } stg_tag_t;

    function automatic int n_stg_f(input int width_o);
        return $clog2(width_o);
    endfunction

    // The shift count must be able to hold width_o-1.
    function automatic bit params_ok(input int width_i, input int width_o, input int width_shift);
        return (width_o >= width_i) && (width_o >= 2) && (width_i >= 1) &&
               ((64'd1 << width_shift) > 64'(width_o - 1));
    endfunction

endpackage

// File: rtl/shift_norm_stage.sv
// One binary-search step: shift left by m when the top m+1 bits are all sign
// bits and the running count stays within width_o-1; registered under i_en.
module shift_norm_stage
    import shift_norm_pipe_pkg::*;
#(
    parameter int m           = 1,
    parameter int width_o     = 16,
    parameter int width_shift = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [width_o-1:0]     i_x,
    input  logic [width_shift-1:0] i_cnt,
    input  stg_tag_t               i_tag,
    output logic [width_o-1:0]     o_x,
    output logic [width_shift-1:0] o_cnt,
    output stg_tag_t               o_tag
);

    logic [m:0]             w_top;
    logic [31:0]            w_cnt_m;
    logic                   w_take;
    logic [width_o-1:0]     w_x_nxt;
    logic [width_shift-1:0] w_cnt_nxt;

    logic [width_o-1:0]     r_x;
    logic [width_shift-1:0] r_cnt;
    stg_tag_t               r_tag;

    assign w_top     = i_x[width_o-1 -: m+1];
    assign w_cnt_m   = 32'(i_cnt) + 32'(m);
    assign w_take    = ((w_top == '0) || (&w_top)) && (w_cnt_m <= 32'(width_o - 1));
    assign w_x_nxt   = w_take ? (i_x << m) : i_x;
    assign w_cnt_nxt = w_take ? width_shift'(w_cnt_m) : i_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x   <= '0;
            r_cnt <= '0;
            r_tag <= '0;
        end else if (i_en) begin
            r_x   <= w_x_nxt;
            r_cnt <= w_cnt_nxt;
            r_tag <= i_tag;
        end
    end

    assign o_x   = r_x;
    assign o_cnt = r_cnt;
    assign o_tag = r_tag;

endmodule

// File: rtl/shift_norm_pipe.sv
// Pipelined left-normalizer: sign-extends i_num to width_o and strips redundant
// sign bits over log2(width_o) stages, reporting the applied shift.
module shift_norm_pipe
    import shift_norm_pipe_pkg::*;
#(
    parameter int width_i     = 8,
    parameter int width_o     = 16,
    parameter int width_shift = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [width_i-1:0]     i_num,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [width_o-1:0]     o_norm,
    output logic [width_shift-1:0] o_shift,
    output logic                   o_zero
);

    localparam int n_stg = n_stg_f(width_o);

    if (!params_ok(width_i, width_o, width_shift)) begin : g_bad_params
        $error("shift_norm_pipe: illegal width_i/width_o/width_shift combination");
    end

    logic [n_stg:0][width_o-1:0]     w_x;
    logic [n_stg:0][width_shift-1:0] w_cnt;
    stg_tag_t [n_stg:0]              w_tag;
    logic                            w_en;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign w_en     = i_ready | ~w_tag[n_stg].valid;
    assign w_x[0]   = width_o'($signed(i_num));
    assign w_cnt[0] = '0;
    assign w_tag[0] = '{zero: (i_num == '0), valid: i_valid};

    for (genvar k = 0; k < n_stg; k++) begin : g_stg
        shift_norm_stage #(
            .m           (2 ** (n_stg - 1 - k)),
            .width_o     (width_o),
            .width_shift (width_shift)
        ) u_stg (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (w_en),
            .i_x   (w_x[k]),
            .i_cnt (w_cnt[k]),
            .i_tag (w_tag[k]),
            .o_x   (w_x[k+1]),
            .o_cnt (w_cnt[k+1]),
            .o_tag (w_tag[k+1])
        );
    end

    assign o_ready = w_en;
    assign o_valid = w_tag[n_stg].valid;
    assign o_norm  = w_x[n_stg];
    assign o_shift = w_cnt[n_stg];
    assign o_zero  = w_tag[n_stg].zero;

endmodule
